c4_move_ctrl: RTL
=================

// Module: c4_move_ctrl
// PURPOSE
//  Sequences Connect-4 play around the combinational win checker. Accepts a column drop from
//  the input/UI side, scans for the landing cell, places the mover's piece, and drives the
//  checker with (mover board, landing pos). It then records win, draw, or turn change.
//  Cell index = row*7 + col; row 0 is the top row and row 5 (bits 35..41) the bottom.
//  Pieces therefore stack toward lower indices.
// PARAMETERS
//  FIRST_PLAYER  0  player to move after reset/new_game (0 or 1)
//  CHECK_WAIT    1  cycles chk_pos/chk_encoding are held stable before chk_done is sampled (>=1)
// PORTS
//  clk           in   1   system clock, rising edge
//  rst_n         in   1   async active-low reset
//  new_game      in   1   sync clear of game state, highest priority after rst_n
//  move_valid    in   1   move request valid
//  move_col      in   3   requested column 0..6
//  move_ready    out  1   controller can accept a move
//  move_ack      out  1   1-cycle pulse: move placed
//  move_err      out  1   1-cycle pulse: move rejected (col>6 or column full)
//  chk_encoding  out  42  to checker: board of player currently to move (comb. mux)
//  chk_pos       out  6   to checker: registered landing index
//  chk_done      in   1   from checker: four-in-a-row through chk_pos
//  board_p0      out  42  player 0 occupancy
//  board_p1      out  42  player 1 occupancy
//  turn          out  1   player to move / being processed
//  game_over     out  1   set on win or draw, held until new_game
//  winner        out  2   00 none, 01 p0, 10 p1, 11 draw
//  move_cnt      out  6   pieces placed, 0..42
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - Boards, chk_pos, move_cnt, winner, game_over, move_ack and move_err all go to 0.
//   - turn=FIRST_PLAYER; state=IDLE.
//  new_game=1 at an edge:
//   - Same clear as reset, from any state. Any in-flight move is aborted with no ack/err.
//   - move_valid is ignored in that cycle.
//  States IDLE -> SCAN -> PLACE -> CHECK -> RESOLVE -> IDLE, plus OVER:
//   IDLE: move_ready = !game_over. On move_valid&&move_ready, latch col.
//    - col>6: pulse move_err next cycle, stay IDLE.
//    - else: row=5, go to SCAN.
//   SCAN: one row per cycle. Test occ = board_p0|board_p1 at row*7+col.
//    - Empty: chk_pos<=row*7+col, go to PLACE.
//    - Occupied and row>0: row--.
//    - Occupied and row==0: column full; pulse move_err, go to IDLE, turn unchanged.
//   PLACE: set bit chk_pos in board of `turn`; move_cnt++; go to CHECK.
//   CHECK: hold chk_pos. chk_encoding = turn ? board_p1 : board_p0 (post-placement).
//    - Count CHECK_WAIT cycles, then register chk_done and go to RESOLVE.
//   RESOLVE: pulse move_ack.
//    - done=1: winner=turn+1, game_over=1, go to OVER, turn unchanged.
//    - else move_cnt==42: winner=11, game_over=1, go to OVER.
//    - else: turn toggles, go to IDLE.
//   OVER: move_ready=0; all moves ignored until new_game.
//  Latency, accept to ack: (rows scanned 1..6) + 1 + CHECK_WAIT + 1 cycles.
//   With CHECK_WAIT=1, an empty column takes 4 cycles.
//  move_ready is low outside IDLE, so no queuing; valid without ready is dropped.
//  Win is tested only for the mover's board; a win on the 42nd piece reports the winner, not draw.
//  move_ack and move_err never assert together; each is high exactly one cycle.
// TESTING
//  1. Reset -> all outputs 0, turn=FIRST_PLAYER, move_ready=1.
//  2. Drop col 3 on an empty board.
//     -> board_p0 bit 38 set, move_ack 4 cycles after accept, turn=1, move_cnt=1.
//  3. Six drops in col 0, then a 7th drop in col 0.
//     -> move_err pulse, boards unchanged, turn unchanged, move_cnt=6.
//  4. move_col=7 -> move_err next cycle, no state change.
//  5. p0 plays cols 0,1,2,3 while p1 plays 0,1,2.
//     -> after the 7th move winner=01, game_over=1; further move_valid ignored.
//  6. new_game asserted during SCAN -> boards cleared, no ack/err, IDLE next cycle.
//     Also: a full 42-move drawn sequence -> winner=11.

Source files
------------

// File: rtl/c4_move_ctrl.sv
// Connect-4 move sequencer: finds the landing cell for a column drop, places the mover's
// piece, presents it to the external win checker and records win, draw or turn change.
module c4_move_ctrl #(
   parameter int FIRST_PLAYER = 0,
   parameter int CHECK_WAIT   = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        new_game,
   input  logic        move_valid,
   input  logic [2:0]  move_col,
   output logic        move_ready,
   output logic        move_ack,
   output logic        move_err,
   output logic [41:0] chk_encoding,
   output logic [5:0]  chk_pos,
   input  logic        chk_done,
   output logic [41:0] board_p0,
   output logic [41:0] board_p1,
   output logic        turn,
   output logic        game_over,
   output logic [1:0]  winner,
   output logic [5:0]  move_cnt
);

   localparam int WAIT_W = (CHECK_WAIT > 1) ? $clog2(CHECK_WAIT) : 1;

   typedef enum logic [2:0] {
      IDLE,
      SCAN,
      PLACE,
      CHECK,
      RESOLVE,
      OVER
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [2:0]          col;
   logic [2:0]          row;
   logic [WAIT_W-1:0]   wait_cnt;
   logic                done_q;
   logic [41:0]         occ_board;
   logic [5:0]          scan_idx;
   logic                occ;
   logic                wait_last;
   logic                accept;

   assign occ_board    = board_p0 | board_p1;
   assign scan_idx     = 6'(row) * 6'd7 + 6'(col);
   assign occ          = occ_board[scan_idx];
   assign wait_last    = (wait_cnt == WAIT_W'(CHECK_WAIT - 1));
   assign chk_encoding = turn ? board_p1 : board_p0;
   assign accept       = move_valid && move_ready && !new_game;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // New_game overrides every transition, aborting a move wherever it is.
   always_comb begin
      state_nxt  = state;
      move_ready = 1'b0;
      case (state)
         IDLE: begin
            move_ready = !game_over;
            if (move_valid && move_ready && (move_col <= 3'd6)) begin
               state_nxt = SCAN;
            end
         end
         SCAN: begin
            if (!occ) begin
               state_nxt = PLACE;
            end else if (row == 3'd0) begin
               state_nxt = IDLE;
            end
         end
         PLACE: begin
            state_nxt = CHECK;
         end
         CHECK: begin
            if (wait_last) begin
               state_nxt = RESOLVE;
            end
         end
         RESOLVE: begin
            if (done_q || (move_cnt == 6'd42)) begin
               state_nxt = OVER;
            end else begin
               state_nxt = IDLE;
            end
         end
         OVER: begin
            state_nxt = OVER;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      if (new_game) begin
         state_nxt = IDLE;
      end
   end

   // Scanning starts at the bottom row and climbs toward row 0 until an empty cell appears.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         board_p0  <= '0;
         board_p1  <= '0;
         chk_pos   <= '0;
         move_cnt  <= '0;
         winner    <= '0;
         game_over <= 1'b0;
         move_ack  <= 1'b0;
         move_err  <= 1'b0;
         turn      <= 1'(FIRST_PLAYER);
         col       <= '0;
         row       <= '0;
         wait_cnt  <= '0;
         done_q    <= 1'b0;
      end else begin
         move_ack <= 1'b0;
         move_err <= 1'b0;
         if (new_game) begin
            board_p0  <= '0;
            board_p1  <= '0;
            chk_pos   <= '0;
            move_cnt  <= '0;
            winner    <= '0;
            game_over <= 1'b0;
            turn      <= 1'(FIRST_PLAYER);
            wait_cnt  <= '0;
            done_q    <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (accept) begin
                     if (move_col > 3'd6) begin
                        move_err <= 1'b1;
                     end else begin
                        col <= move_col;
                        row <= 3'd5;
                     end
                  end
               end
               SCAN: begin
                  if (!occ) begin
                     chk_pos <= scan_idx;
                  end else if (row != 3'd0) begin
                     row <= row - 3'd1;
                  end else begin
                     move_err <= 1'b1;
                  end
               end
               PLACE: begin
                  if (turn) begin
                     board_p1 <= board_p1 | (42'd1 << chk_pos);
                  end else begin
                     board_p0 <= board_p0 | (42'd1 << chk_pos);
                  end
                  move_cnt <= move_cnt + 6'd1;
                  wait_cnt <= '0;
               end
               CHECK: begin
                  if (wait_last) begin
                     done_q <= chk_done;
                  end else begin
                     wait_cnt <= wait_cnt + WAIT_W'(1);
                  end
               end
               RESOLVE: begin
                  move_ack <= 1'b1;
                  if (done_q) begin
                     winner    <= turn ? 2'b10 : 2'b01;
                     game_over <= 1'b1;
                  end else if (move_cnt == 6'd42) begin
                     winner    <= 2'b11;
                     game_over <= 1'b1;
                  end else begin
                     turn <= ~turn;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule
